// File: rtl/mult_sequencer_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
// Imported by the interface, the counter and the top.
package mult_sequencer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mult_sequencer_if.sv
// CPU-control / datapath handshake bundle of the multiply sequencer.
// master = CPU control side, slave = sequencer.
interface mult_sequencer_if
  import mult_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             Start;
  logic             Ack;
  logic             Q0;
  logic             Load;
  logic             Add;
  logic             Shift;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;

  modport master (
    output Start, Ack, Q0,
    input  Load, Add, Shift, Busy, Done, Count
  );

  modport slave (
    input  Start, Ack, Q0,
    output Load, Add, Shift, Busy, Done, Count
  );

endinterface

// File: rtl/mult_sequencer_iter_counter.sv
// Mod-WIDTH iteration counter with sync clear and a last-step flag.
// Last marks the final add/shift iteration (Out == WIDTH-1).
module iter_counter
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             En,
  output logic [CNT_W-1:0] Out,
  output logic             Last
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign Last = (cnt_q == MAX);
  assign Out  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (Clear) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = Last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the multi-cycle shift-add multiplier datapath.
// Sequences load, WIDTH add/shift steps, then a Done/Ack handshake.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  mult_sequencer_if.slave        bus
);

  state_e state_q;
  state_e state_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_last;

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (cnt_clr),
    .En    (cnt_en),
    .Out   (bus.Count),
    .Last  (cnt_last)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start beats Ack in DONE so back-to-back multiplies need no ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.Start) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (cnt_last) state_d = DONE;
      DONE: begin
        if (bus.Start) begin
          state_d = LOAD;
        end else if (bus.Ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = (state_q == LOAD);
    cnt_en    = (state_q == RUN);
    bus.Load  = (state_q == LOAD);
    bus.Shift = (state_q == RUN);
    bus.Busy  = (state_q == LOAD) || (state_q == RUN);
    bus.Done  = (state_q == DONE);
    bus.Add   = (state_q == RUN) && bus.Q0;
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: vector tables plus reset-abort sequence.
module tb_mult_sequencer;
  import mult_sequencer_pkg::*;

  typedef struct {
    logic       start;
    logic       ack;
    logic       q0;
    logic [7:0] exp;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  mult_sequencer_if #(.CNT_W(3)) bus ();

  mult_sequencer #(
    .WIDTH (8),
    .CNT_W (3)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // {Load, Add, Shift, Busy, Done, Count[2:0]}
  function automatic logic [7:0] pk(
    input logic l, input logic a, input logic s,
    input logic b, input logic d, input int c
  );
    logic [2:0] cc;
    cc = 3'(c);
    return {l, a, s, b, d, cc};
  endfunction

  function automatic logic [7:0] outs();
    return {bus.Load, bus.Add, bus.Shift, bus.Busy, bus.Done, bus.Count};
  endfunction

  task automatic chk(input string tag, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got L/A/S/B/D/cnt=%b want %b at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic s, input logic a, input logic q,
                         input logic [7:0] e, input string tag);
    vec_t v;
    v.start = s;
    v.ack   = a;
    v.q0    = q;
    v.exp   = e;
    v.tag   = tag;
    tv.push_back(v);
  endtask

  // Entered at posedge+1; inputs held for the cycle, outputs checked mid-cycle.
  task automatic run_table();
    foreach (tv[i]) begin
      bus.Start = tv[i].start;
      bus.Ack   = tv[i].ack;
      bus.Q0    = tv[i].q0;
      #4;
      chk($sformatf("%s[%0d]", tv[i].tag, i), outs(), tv[i].exp);
      @(posedge clk);
      #1;
    end
    tv.delete();
  endtask

  task automatic add_run(input logic [7:0] m, input logic start3_7);
    logic b;
    logic s;
    for (int k = 0; k < 8; k++) begin
      b = m[k];
      s = start3_7 && (k == 3 || k == 7);
      add_vec(s, 1'b0, b, pk(0, b, 1, 1, 0, k), "run");
    end
  endtask

  logic [7:0] mul;
  int         done_seen;

  initial begin
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    bus.Q0    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", outs(), pk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single multiply with 0xA5, then a 5-cycle Done hold and Ack.
    mul = 8'b1010_0101;
    add_vec(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "idle_start");
    add_vec(0, 0, 1, pk(1, 0, 0, 1, 0, 0), "load");
    add_run(mul, 1'b0);
    for (int k = 0; k < 5; k++)
      add_vec(0, 0, 1, pk(0, 0, 0, 0, 1, 0), "done_hold");
    add_vec(0, 1, 1, pk(0, 0, 0, 0, 1, 0), "done_ack");
    add_vec(0, 0, 0, pk(0, 0, 0, 0, 0, 0), "idle_after");
    add_vec(0, 0, 1, pk(0, 0, 0, 0, 0, 0), "idle_q0");
    run_table();

    // Start pulses at Count 3 and 7 are ignored.
    mul = 8'b0011_1100;
    add_vec(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "idle_start2");
    add_vec(0, 0, 0, pk(1, 0, 0, 1, 0, 0), "load2");
    add_run(mul, 1'b1);
    add_vec(0, 0, 0, pk(0, 0, 0, 0, 1, 0), "done2");
    add_vec(0, 1, 0, pk(0, 0, 0, 0, 1, 0), "done2_ack");
    add_vec(0, 0, 0, pk(0, 0, 0, 0, 0, 0), "idle2");
    run_table();

    // Start held high: DONE lasts one cycle then LOAD, period 10.
    mul = 8'b1000_0001;
    add_vec(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "b2b_idle");
    for (int r = 0; r < 3; r++) begin
      add_vec(1, 0, 0, pk(1, 0, 0, 1, 0, 0), "b2b_load");
      for (int k = 0; k < 8; k++)
        add_vec(1, 0, mul[k], pk(0, mul[k], 1, 1, 0, k), "b2b_run");
      add_vec(1, 0, 0, pk(0, 0, 0, 0, 1, 0), "b2b_done");
    end
    add_vec(0, 0, 0, pk(1, 0, 0, 1, 0, 0), "b2b_load_last");
    add_run(8'h00, 1'b0);
    add_vec(0, 0, 0, pk(0, 0, 0, 0, 1, 0), "b2b_done_last");
    // Start and Ack together in DONE: Start wins.
    add_vec(1, 1, 0, pk(0, 0, 0, 0, 1, 0), "both_done");
    add_vec(0, 0, 0, pk(1, 0, 0, 1, 0, 0), "both_load");
    add_run(8'hff, 1'b0);
    add_vec(0, 1, 0, pk(0, 0, 0, 0, 1, 0), "both_ack");
    add_vec(0, 0, 0, pk(0, 0, 0, 0, 0, 0), "both_idle");
    run_table();

    // Reset three cycles while Count==4 aborts the multiply.
    add_vec(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "rst_idle");
    add_vec(0, 0, 0, pk(1, 0, 0, 1, 0, 0), "rst_load");
    for (int k = 0; k < 4; k++)
      add_vec(0, 0, 0, pk(0, 0, 1, 1, 0, k), "rst_run");
    run_table();
    bus.Q0 = 1'b0;
    #2;
    chk("run_cnt4", outs(), pk(0, 0, 1, 1, 0, 4));
    rst    = 1'b1;
    bus.Q0 = 1'b1;
    #2;
    chk("rst_async", outs(), pk(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", outs(), pk(0, 0, 0, 0, 0, 0));
    end
    rst = 1'b0;
    #4;
    chk("rst_release", outs(), pk(0, 0, 0, 0, 0, 0));
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) done_seen++;
    end
    chk("rst_no_done", 8'(done_seen), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Control unit for the multi-cycle shift-add multiplier datapath in the MIPS CPU. On a start request it sequences one multiply: load the operands, run WIDTH add/shift iterations, then signal completion. It owns a mod-WIDTH iteration counter and drives the datapath strobes, with a start/done/ack handshake toward the CPU control.

Parameters:
WIDTH, 8, number of add/shift iterations (operand width); must be >= 2
CNT_W, 3, iteration counter width; equals clog2(WIDTH)

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request a multiply; sampled in IDLE and DONE only
Ack  input  1  CPU acknowledges the result; sampled in DONE only
Q0  input  1  current LSB of the datapath multiplier register
Load  output  1  datapath loads operands and clears the product high half
Add  output  1  datapath adds the multiplicand into the product high half this cycle
Shift  output  1  datapath shifts the product/multiplier right by 1 this cycle
Busy  output  1  high in LOAD and RUN
Done  output  1  high in DONE (level, held until handshake completes)
Count  output  CNT_W  current iteration index

Behaviour:
- Reset is asynchronous and active-high. Clock is Clk, reset is Reset. While Reset is high: state=IDLE, Count=0, and Load, Add, Shift, Busy and Done are all 0.
- Reset asserted mid-operation aborts the multiply immediately. No Done is produced.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: Start=1 -> LOAD; otherwise stay.
- LOAD: always one cycle. Load=1, Busy=1, Count cleared to 0. Next state is RUN.
- RUN: Shift=1, Busy=1, Add=Q0 (Mealy, combinational from Q0).
  - Count increments by 1 each RUN cycle, modulo WIDTH.
  - When Count==WIDTH-1 (last iteration): Count wraps to 0 and next state is DONE.
  - Otherwise stay in RUN.
- DONE: Done=1, Busy=0.
  - Start=1 -> LOAD (implicit ack, back-to-back multiply). Start takes priority if Start and Ack are both high.
  - Ack=1 (Start=0) -> IDLE.
  - Neither -> stay; Done stays high.
- Start while in LOAD or RUN is ignored; no queuing.
- Q0 is ignored outside RUN. Add is 0 in all other states.
- Load, Shift, Busy and Done are Moore outputs decoded from the state register, with no extra pipeline stage.
- Latency: Start seen in IDLE at edge n gives LOAD in cycle n+1, RUN in cycles n+2..n+WIDTH+1, and Done=1 from cycle n+WIDTH+2. With WIDTH=8 that is 10 cycles from Start to Done.
- Count is held outside LOAD/RUN. It is 0 on entering DONE.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11
  - default WIDTH/CNT_W constants
- One sub-module: iter_counter, a mod-WIDTH up-counter.
  - Ports: Clk, Reset (async active-high), Clear (sync), En, Out[CNT_W], Last.
  - Last = (Out==WIDTH-1).
  - The sequencer drives Clear in LOAD and En in RUN.

Test Plan:
- Reset held for 3 cycles mid-RUN (Count=4) -> next cycle state=IDLE, Count=0, and Busy, Done, Load, Shift, Add all 0. No Done follows.
- Start pulse in IDLE, Q0 driven from multiplier 8'b1010_0101 (shifting LSB-first) -> Load=1 for exactly 1 cycle, then Shift=1 for 8 cycles. Add=1 only at Count=0,2,5,7. Done=1 at cycle 10 after Start.
- After Done, hold Ack=0 for 5 cycles -> Done stays 1 and Count stays 0. Then Ack=1 for 1 cycle -> IDLE, Done=0 the next cycle.
- Start held high continuously -> back-to-back multiplies. DONE lasts exactly 1 cycle, then LOAD. Period is 10 cycles; Ack is not required.
- Start pulses during RUN at Count=3 and at Count=7 -> no restart, Count sequence 0..7 is unaffected, and a single Done results.
- Start=1 and Ack=1 together in DONE -> LOAD next cycle (Start wins) and Busy=1.
